if_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, selects
//  the next PC (sequential, branch, jump), drives the instruction-memory address
//  and latches {pc+4, instr, valid} for ID. Obeys the hazard unit's pcwrite /

---
 rtl/if_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, picks the next PC, and latches {pc+4, instr, valid} for decode.
// Also keeps saturating stall and flush counters for debug.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pcwrite_i,
    input  logic             ifid_write_i,
    input  logic             ifid_flush_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_tgt_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_tgt_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      pc_next;
    logic [31:0]      ifid_pc4_q;
    logic [31:0]      ifid_instr_q;
    logic             ifid_valid_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             flush_load;

    // PC+4 wraps naturally modulo 2^32.
    assign pc_plus4   = pc_q + 32'd4;
    assign flush_load = ifid_write_i & ifid_flush_i;

    // Next-PC select: hold on stall, branch beats jump, otherwise sequential.
    always_comb begin
        pc_next = pc_q;
        if (pcwrite_i) begin
            if (branch_i) begin
                pc_next = branch_tgt_i;
            end else if (jump_i) begin
                pc_next = jump_tgt_i;
            end else begin
                pc_next = pc_plus4;
            end
        end
    end

    // PC register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // IF/ID register: write enable dominates flush; flush inserts a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else if (ifid_write_i) begin
            if (ifid_flush_i) begin
                ifid_pc4_q   <= 32'd0;
                ifid_instr_q <= 32'd0;
                ifid_valid_q <= 1'b0;
            end else begin
                ifid_pc4_q   <= pc_plus4;
                ifid_instr_q <= imem_data_i;
                ifid_valid_q <= 1'b1;
            end
        end
    end

    // Saturating stall counter: counts edges where the PC was held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (!pcwrite_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    // Saturating flush counter: counts edges where IF/ID loaded a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flush_cnt_q <= '0;
        end else if (flush_load && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule
